hive_pc_vect_ring: RTL and testbench
====================================

# hive_pc_vect_ring

Per-thread program counter (PC) state and next-PC selection for the barrel-threaded core. It consumes the stage-7 clear and interrupt strobes (`clt_i`, `irq_i`) produced by the vector control ring, plus branch, jump and ISR-return requests from the decoder. Each cycle it updates the PC of the thread currently in its slot and presents the registered fetch address and thread ID to stage 0. It also keeps one interrupt return PC per thread and reports interrupt protocol errors.

## Interface
Parameters:
- `THREADS`, 8, number of threads (power of 2).
- `PC_W`, 16, PC width.
- `CLT_BASE`, 'h0000, clear-vector base address.
- `IRQ_BASE`, 'h0040, interrupt-vector base address.
- `VECT_SPC`, 8, per-thread vector spacing in words (power of 2).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `id_i`  in  $clog2(THREADS)  thread ID occupying the slot this cycle.
- `clt_i`  in  1  clear thread `id_i`.
- `irq_i`  in  1  interrupt thread `id_i`.
- `irt_i`  in  1  ISR return for thread `id_i`.
- `jmp_i`  in  1  absolute jump.
- `jmp_addr_i`  in  PC_W  jump target.
- `brn_i`  in  1  relative branch taken.
- `brn_ofs_i`  in  PC_W  two's-complement branch offset.
- `pc_o`  out  PC_W  registered fetch PC.
- `id_o`  out  $clog2(THREADS)  registered thread ID accompanying `pc_o`.
- `vect_o`  out  1  registered; slot was vectored by clt or irq.
- `insvc_o`  out  THREADS  per-thread in-service flags.
- `irq_er_o`  out  1  1-cycle pulse: irq while in service.
- `irt_er_o`  out  1  1-cycle pulse: irt while not in service.

## Operation
- State:
  - `pc[THREADS]`, PC_W bits each.
  - `rpc[THREADS]`, PC_W bits each (return PCs).
  - `insvc[THREADS]`, 1 bit each.
- Slot thread is `t = id_i`.
- `cur = pc[t]`.
- Normal next PC `npc` is selected by priority:
  1. `jmp_i`: `jmp_addr_i`.
  2. `brn_i`: `cur + 1 + brn_ofs_i`.
  3. Otherwise: `cur + 1`.
- All PC arithmetic is modulo 2^PC_W, so wrap-around is silent: `'hFFFF + 1 = 'h0000`.
- The write to `pc[t]` is selected by priority (highest first):
  - `clt_i`:
    - `pc[t] <= CLT_BASE + t*VECT_SPC`.
    - `insvc[t] <= 0`, `rpc[t] <= 0`.
    - `irq_i` and `irt_i` are ignored; no error pulses.
  - `irq_i & !insvc[t]`:
    - `rpc[t] <= npc`, so the current instruction's control effect is kept.
    - `pc[t] <= IRQ_BASE + t*VECT_SPC`.
    - `insvc[t] <= 1`.
  - `irq_i & insvc[t]`:
    - Pulse `irq_er_o`.
    - The irq is dropped; `pc[t] <= npc`; `rpc[t]` is unchanged.
  - `irt_i & insvc[t]`: `pc[t] <= rpc[t]`, `insvc[t] <= 0`. `jmp_i` and `brn_i` are ignored.
  - `irt_i & !insvc[t]`: pulse `irt_er_o`; `pc[t] <= npc`.
  - Otherwise: `pc[t] <= npc`.
- If `irq_i` and `irt_i` are asserted together with `insvc[t]=1`: `irq_er_o` pulses and the irt is serviced.
- Only slot `t` is modified in a cycle; all other threads hold their state.
- `vect_o` is 1 in the output cycle when a clt or an accepted irq was taken.
- `id_o` is `id_i` delayed by one cycle. The block does not check ID sequencing.

## Timing
- Latency is 1 clock from slot inputs to `pc_o`/`id_o`/`vect_o`/error pulses.
- `pc_o` shows the updated `pc[t]`, i.e. the next fetch address for thread `t`.
- `pc[t]` is read combinationally, so back-to-back cycles on the same ID (degenerate, `THREADS=1`) see the value written the previous cycle.
- `insvc_o` shows the state register directly and updates the same edge as `pc`.
- Reset, at any point including mid-ISR:
  - All `pc`, `rpc`, `insvc` = 0.
  - `pc_o` = 0, `id_o` = 0, `vect_o` = 0, `irq_er_o` = 0, `irt_er_o` = 0.
- The upstream vector ring asserts clt for every thread after reset. The first slot of each thread therefore loads `CLT_BASE + t*VECT_SPC`.
- Error outputs are 0 in every cycle that carries no error.

## Test plan
- Reset release, then `clt_i`=1 for IDs 0..7 in sequence → `pc_o` = `0x0000`, `0x0008`, …, `0x0038`; `vect_o`=1 each cycle; `insvc_o`=0.
- Thread 3 at PC `0x0100`, plain slots → `pc_o` = `0x0101`, then `0x0102` on its next turns. Other threads are unchanged.
- Thread 2 at `0x0200` with `irq_i` and `jmp_i` (`jmp_addr_i`=`0x0300`):
  - `pc_o`=`0x0050`, `insvc_o[2]`=1, `vect_o`=1.
  - A later `irt_i` gives `pc_o`=`0x0300` and `insvc_o[2]`=0.
- Thread 5 in service:
  - `irq_i` → `irq_er_o` pulses one cycle; PC increments; `rpc` is preserved, checked by a subsequent `irt_i` returning the original address.
  - `irt_i` on a thread not in service → `irt_er_o` pulse.
- Branch edge cases:
  - Thread 1 at `0xFFFF` with no branch → `0x0000`.
  - Branch at `0x0010` with offset `0xFFF0` (-16) → `0x0001`.
- Thread 4 in service (`rpc`=`0x0123`):
  - Assert `rst_i` mid-ISR → all outputs and flags are 0 asynchronously.
  - Then `clt_i` → `pc_o`=`0x0020`. A following `irt_i` gives `irt_er_o`=1.

Source files
------------

// File: rtl/hive_pc_vect_ring.sv
// hive_pc_vect_ring: per-thread PC, ISR return PC and in-service state with vectored next-PC selection
module hive_pc_vect_ring #(
  parameter int THREADS = 8,
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] CLT_BASE = 'h0000,
  parameter logic [PC_W-1:0] IRQ_BASE = 'h0040,
  parameter int VECT_SPC = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(THREADS)-1:0] id_i,
  input  logic                       clt_i,
  input  logic                       irq_i,
  input  logic                       irt_i,
  input  logic                       jmp_i,
  input  logic [PC_W-1:0]            jmp_addr_i,
  input  logic                       brn_i,
  input  logic [PC_W-1:0]            brn_ofs_i,
  output logic [PC_W-1:0]            pc_o,
  output logic [$clog2(THREADS)-1:0] id_o,
  output logic                       vect_o,
  output logic [THREADS-1:0]         insvc_o,
  output logic                       irq_er_o,
  output logic                       irt_er_o
);
  localparam int VS_SH = $clog2(VECT_SPC);
  logic [PC_W-1:0] pc [THREADS];
  logic [PC_W-1:0] rpc [THREADS];
  logic [THREADS-1:0] insvc;
  logic [PC_W-1:0] cur, npc, ofs, nxt;
  logic in_t, irq_ok, irq_er, irt_ok, irt_er;
  always_comb begin
    cur = pc[id_i];
    in_t = insvc[id_i];
    ofs = PC_W'(id_i) << VS_SH;
    npc = jmp_i ? jmp_addr_i : brn_i ? cur + PC_W'(1) + brn_ofs_i : cur + PC_W'(1);
    irq_ok = irq_i & ~in_t & ~clt_i;
    irq_er = irq_i & in_t & ~clt_i;
    // a rejected irq does not block an irt issued in the same slot
    irt_ok = irt_i & in_t & ~clt_i;
    irt_er = irt_i & ~in_t & ~clt_i & ~irq_i;
    nxt = clt_i ? CLT_BASE + ofs : irq_ok ? IRQ_BASE + ofs : irt_ok ? rpc[id_i] : npc;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < THREADS; i++) begin
        pc[i] <= '0;
        rpc[i] <= '0;
      end
      insvc <= '0;
      pc_o <= '0;
      id_o <= '0;
      vect_o <= 1'b0;
      irq_er_o <= 1'b0;
      irt_er_o <= 1'b0;
    end else begin
      pc[id_i] <= nxt;
      if (clt_i) rpc[id_i] <= '0;
      else if (irq_ok) rpc[id_i] <= npc;
      if (clt_i | irt_ok) insvc[id_i] <= 1'b0;
      else if (irq_ok) insvc[id_i] <= 1'b1;
      pc_o <= nxt;
      id_o <= id_i;
      vect_o <= clt_i | irq_ok;
      irq_er_o <= irq_er;
      irt_er_o <= irt_er;
    end
  end
  assign insvc_o = insvc;
endmodule

// File: tb/tb_hive_pc_vect_ring.sv
// tb_hive_pc_vect_ring: directed vectors with a queue scoreboard checked one cycle after each slot
module tb_hive_pc_vect_ring;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [2:0] id_i = '0, id_o;
  logic clt_i = 0, irq_i = 0, irt_i = 0, jmp_i = 0, brn_i = 0;
  logic [15:0] jmp_addr_i = '0, brn_ofs_i = '0, pc_o;
  logic vect_o, irq_er_o, irt_er_o;
  logic [7:0] insvc_o;
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] pc;
    logic [2:0] id;
    logic vect, qe, te;
    logic [7:0] sv;
  } exp_t;
  exp_t q[$];
  localparam logic [4:0] P = 5'b00000, C = 5'b10000, Q = 5'b01000, R = 5'b00100, J = 5'b00010, B = 5'b00001;

  hive_pc_vect_ring dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_i(id_i), .clt_i(clt_i), .irq_i(irq_i), .irt_i(irt_i),
    .jmp_i(jmp_i), .jmp_addr_i(jmp_addr_i), .brn_i(brn_i), .brn_ofs_i(brn_ofs_i),
    .pc_o(pc_o), .id_o(id_o), .vect_o(vect_o), .insvc_o(insvc_o),
    .irq_er_o(irq_er_o), .irt_er_o(irt_er_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic slot(input logic [2:0] id, input logic [4:0] ctl, input logic [15:0] arg,
                      input logic [15:0] epc, input logic ev, input logic eqe, input logic ete,
                      input logic [7:0] esv);
    exp_t e;
    id_i = id;
    {clt_i, irq_i, irt_i, jmp_i, brn_i} = ctl;
    jmp_addr_i = arg;
    brn_ofs_i = arg;
    e.pc = epc; e.id = id; e.vect = ev; e.qe = eqe; e.te = ete; e.sv = esv;
    q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, 32'(pc_o), 0);
    chk({tag, "_id"}, 32'(id_o), 0);
    chk({tag, "_vect"}, 32'(vect_o), 0);
    chk({tag, "_insvc"}, 32'(insvc_o), 0);
    chk({tag, "_irq_er"}, 32'(irq_er_o), 0);
    chk({tag, "_irt_er"}, 32'(irt_er_o), 0);
  endtask

  always @(posedge clk_i) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_o", 32'(pc_o), 32'(e.pc));
      chk("id_o", 32'(id_o), 32'(e.id));
      chk("vect_o", 32'(vect_o), 32'(e.vect));
      chk("irq_er_o", 32'(irq_er_o), 32'(e.qe));
      chk("irt_er_o", 32'(irt_er_o), 32'(e.te));
      chk("insvc_o", 32'(insvc_o), 32'(e.sv));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk_zero("reset");
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) slot(3'(i), C, 16'h0, 16'(i * 8), 1, 0, 0, 8'h00);
    slot(3, J, 16'h0100, 16'h0100, 0, 0, 0, 8'h00);
    slot(6, P, 16'h0, 16'h0031, 0, 0, 0, 8'h00);
    slot(3, P, 16'h0, 16'h0101, 0, 0, 0, 8'h00);
    slot(0, P, 16'h0, 16'h0001, 0, 0, 0, 8'h00);
    slot(3, P, 16'h0, 16'h0102, 0, 0, 0, 8'h00);
    slot(6, P, 16'h0, 16'h0032, 0, 0, 0, 8'h00);
    slot(2, J, 16'h0200, 16'h0200, 0, 0, 0, 8'h00);
    slot(2, Q | J, 16'h0300, 16'h0050, 1, 0, 0, 8'h04);
    slot(7, P, 16'h0, 16'h0039, 0, 0, 0, 8'h04);
    slot(2, R, 16'h0, 16'h0300, 0, 0, 0, 8'h00);
    slot(5, J, 16'h0500, 16'h0500, 0, 0, 0, 8'h00);
    slot(5, Q, 16'h0, 16'h0068, 1, 0, 0, 8'h20);
    slot(5, P, 16'h0, 16'h0069, 0, 0, 0, 8'h20);
    slot(5, Q, 16'h0, 16'h006A, 0, 1, 0, 8'h20);
    slot(5, P, 16'h0, 16'h006B, 0, 0, 0, 8'h20);
    slot(5, R, 16'h0, 16'h0501, 0, 0, 0, 8'h00);
    slot(5, R, 16'h0, 16'h0502, 0, 0, 1, 8'h00);
    slot(5, Q, 16'h0, 16'h0068, 1, 0, 0, 8'h20);
    slot(5, Q | R, 16'h0, 16'h0503, 0, 1, 0, 8'h00);
    slot(1, J, 16'hFFFF, 16'hFFFF, 0, 0, 0, 8'h00);
    slot(1, P, 16'h0, 16'h0000, 0, 0, 0, 8'h00);
    slot(1, J, 16'h0010, 16'h0010, 0, 0, 0, 8'h00);
    slot(1, B, 16'hFFF0, 16'h0001, 0, 0, 0, 8'h00);
    slot(1, J | B, 16'h0020, 16'h0020, 0, 0, 0, 8'h00);
    slot(1, B, 16'h0004, 16'h0025, 0, 0, 0, 8'h00);
    slot(0, C | Q, 16'h0, 16'h0000, 1, 0, 0, 8'h00);
    slot(2, Q, 16'h0, 16'h0050, 1, 0, 0, 8'h04);
    slot(2, C | R, 16'h0, 16'h0010, 1, 0, 0, 8'h00);
    slot(2, R, 16'h0, 16'h0011, 0, 0, 1, 8'h00);
    slot(4, J, 16'h0122, 16'h0122, 0, 0, 0, 8'h00);
    slot(4, Q, 16'h0, 16'h0060, 1, 0, 0, 8'h10);
    rst_i = 1'b1;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    slot(4, C, 16'h0, 16'h0020, 1, 0, 0, 8'h00);
    slot(4, R, 16'h0, 16'h0021, 0, 0, 1, 8'h00);
    slot(3, P, 16'h0, 16'h0001, 0, 0, 0, 8'h00);
    id_i = '0;
    {clt_i, irq_i, irt_i, jmp_i, brn_i} = P;
    repeat (2) @(negedge clk_i);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
